// File: rtl/div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : div_unit                                                           |
// | Multi-cycle radix-2 restoring divider (div/divu) that stalls the pipeline.  |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_req
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH:0]     sr_q, sr_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH+1:0]     trial;
    logic [2*WIDTH:0]     step;
    logic [WIDTH-1:0]     q_mag, r_mag, q_fix, r_fix;

    // Operand magnitudes; the most negative value maps onto its own unsigned magnitude.
    always_comb begin
        a_neg = signed_div & opdata1[WIDTH-1];
        b_neg = signed_div & opdata2[WIDTH-1];
        a_mag = a_neg ? -opdata1 : opdata1;
        b_mag = b_neg ? -opdata2 : opdata2;
    end

    // sr_q[2W:W-1] is the partial remainder already shifted left by one bit.
    always_comb begin
        trial = sr_q[2*WIDTH:WIDTH-1] - {2'b00, divisor_q};
        if (trial[WIDTH+1]) begin
            step = {sr_q[2*WIDTH-1:0], 1'b0};
        end else begin
            step = {trial[WIDTH:0], sr_q[WIDTH-2:0], 1'b1};
        end
        q_mag = step[WIDTH-1:0];
        r_mag = step[2*WIDTH-1:WIDTH];
        q_fix = neg_quo_q ? -q_mag : q_mag;
        r_fix = neg_rem_q ? -r_mag : r_mag;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        if (annul) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sr_d      = {{(WIDTH+1){1'b0}}, a_mag};
                        divisor_d = b_mag;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = '0;
                        state_d   = (opdata2 == '0) ? S_BYZERO : S_ON;
                    end
                end
                S_BYZERO: begin
                    result_d = '0;
                    state_d  = S_END;
                end
                S_ON: begin
                    sr_d  = step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_d = {r_fix, q_fix};
                        cnt_d    = '0;
                        state_d  = S_END;
                    end
                end
                S_END: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign ready     = (state_q == S_END);
    assign stall_req = start & ~ready & ~annul;
    assign result    = result_q;

endmodule
`default_nettype wire
